rf_riscv_cfg: RTL
=================

// Module: rf_riscv_cfg
// PURPOSE
// - Parametrised 2-read/1-write integer register file for the RISC-V core; successor to the fixed 32x32 file.
// - Generalised width/depth; entry 0 hardwired to zero; optional write-to-read bypass.
// - Hardware clear sequencer zeroes all entries after reset, so no X reaches the datapath after boot.
// - Sits between decode (read addresses) and writeback (write port); ready_o gates core start.
// PARAMETERS
// - DATA_W   32  data width of each entry, in bits.
// - REG_NUM  32  number of entries (power of two, >= 2).
// - ADDR_W   $clog2(REG_NUM)  address width (derived; do not override).
// - BYPASS   1   1: a same-cycle write is forwarded to matching read ports; 0: reads show stored value.
// PORTS
// - clk_i           in   1       clock, all state on rising edge
// - rst_ni          in   1       asynchronous reset, active-low
// - write_enable_i  in   1       write strobe
// - write_addr_i    in   ADDR_W  write address
// - write_data_i    in   DATA_W  write data
// - read_addr1_i    in   ADDR_W  read port 1 address
// - read_addr2_i    in   ADDR_W  read port 2 address
// - read_data1_o    out  DATA_W  read port 1 data (combinational)
// - read_data2_o    out  DATA_W  read port 2 data (combinational)
// - ready_o         out  1       1 = clear complete, file usable
// - parity_err_o    out  2       per-read-port parity error (only with RF_PARITY_EN)
// BEHAVIOUR
// - Reset (rst_ni=0, async): FSM->CLEAR, clr_cnt=0, ready_o=0; read_data*_o=0; parity_err_o=0.
// - FSM CLEAR: each rising edge writes 0 to entry clr_cnt, clr_cnt++ ; on edge clearing REG_NUM-1 -> RUN.
// - ready_o=1 exactly REG_NUM rising edges after rst_ni deasserts; stays 1 until next reset.
// - During CLEAR: write_enable_i ignored (write dropped, no queuing); both read ports return 0.
// - Reset asserted mid-CLEAR or in RUN: immediate return to CLEAR, clr_cnt=0; full clear restarts.
// - RUN: write_enable_i=1 and write_addr_i!=0 -> entry updated on rising edge; write to addr 0 discarded.
// - Reads: addr 0 -> 0 always; else stored entry, zero latency (combinational from address).
// - BYPASS=1: if RUN & write_enable_i & write_addr_i==read_addrN_i & addr!=0 -> read_dataN_o=write_data_i.
// - BYPASS=0: same case returns the old value; the new value is visible the cycle after the edge.
// - Both read ports may address the same entry; each is independent, no conflict.
// - No reset of the storage array by rst_ni itself; zeroing is done only by the CLEAR sequence.
// CONFIGURATION
// - Macro RF_PARITY_EN defined: each entry stores DATA_W+1 bits (even parity over data).
//   - Parity computed on write (CLEAR writes parity 0); checked on read, combinational.
//   - parity_err_o[N-1]=1 when port N reads a nonzero addr in RUN whose stored parity mismatches.
//   - Bypassed reads and addr-0 reads never flag; output not sticky.
// - Macro undefined: no parity storage, port parity_err_o absent, array is DATA_W wide.
// TESTING
// - Reset release, REG_NUM=32: ready_o low for 32 edges, high on 32nd; every addr reads 0.
// - RUN: write x5=0xDEADBEEF; next cycle read1=5 -> 0xDEADBEEF; write x0=0x1234 -> read x0 = 0.
// - BYPASS=1: same cycle we=1 addr=7 data=0xA5A5A5A5, read2=7 -> 0xA5A5A5A5; BYPASS=0 -> old value.
// - Write during CLEAR (cycle 3, addr 9, 0xFFFF) -> after ready_o, x9 reads 0.
// - Reset pulsed at clear cycle 10, and again in RUN after writing x3=0x55 -> ready_o drops to 0 at once;
//   ready_o returns 32 edges after release; x3 reads 0.
// - RF_PARITY_EN: write x4=0x1, force-flip stored bit0 -> parity_err_o=2'b01 on read1=4; read x0 -> 0.
// - DATA_W=64, REG_NUM=16: write/readback 0x0123456789ABCDEF on x15; ready_o after 16 edges.

Source files
------------

// File: rtl/rf_riscv_cfg.sv
// Parametrised 2-read/1-write RISC-V integer register file with post-reset clear sequencer.
// Optional per-entry even parity when RF_PARITY_EN is defined.
module rf_riscv_cfg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned ADDR_W  = $clog2(REG_NUM),
  parameter int unsigned BYPASS  = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              write_enable_i,
  input  logic [ADDR_W-1:0] write_addr_i,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic [ADDR_W-1:0] read_addr1_i,
  input  logic [ADDR_W-1:0] read_addr2_i,
  output logic [DATA_W-1:0] read_data1_o,
  output logic [DATA_W-1:0] read_data2_o,
  output logic              ready_o
`ifdef RF_PARITY_EN
  ,
  output logic [1:0]        parity_err_o
`endif
);

`ifdef RF_PARITY_EN
  localparam int unsigned ENTRY_W = DATA_W + 1;
`else
  localparam int unsigned ENTRY_W = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              ready_q, ready_d;

  logic [ENTRY_W-1:0] mem_q [REG_NUM];
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [ENTRY_W-1:0] mem_wdata;

  logic [ADDR_W-1:0]  raddr    [2];
  logic [ENTRY_W-1:0] rd_entry [2];
  logic [DATA_W-1:0]  rdata    [2];
`ifdef RF_PARITY_EN
  logic [1:0]         perr;
`endif

  logic run;
  assign run = (state_q == S_RUN);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // Clear sequencer: one entry per edge, RUN after the last entry is zeroed
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = S_RUN;
          clr_cnt_d = '0;
          ready_d   = 1'b1;
        end
      end
      S_RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  // Write port mux: the clear sequencer owns the array until RUN
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = write_addr_i;
    mem_wdata = '0;
    if (!run) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
    end else if (write_enable_i && (write_addr_i != '0)) begin
      mem_we = 1'b1;
`ifdef RF_PARITY_EN
      mem_wdata = {^write_data_i, write_data_i};
`else
      mem_wdata = write_data_i;
`endif
    end
  end

  // Storage is deliberately not reset; the clear sequence zeroes it
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign raddr[0] = read_addr1_i;
  assign raddr[1] = read_addr2_i;

  // Read ports: zero during clear and for x0, optional same-cycle forwarding
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_entry[p] = mem_q[raddr[p]];
      rdata[p]    = '0;
`ifdef RF_PARITY_EN
      perr[p]     = 1'b0;
`endif
      if (run && (raddr[p] != '0)) begin
        if ((BYPASS != 0) && write_enable_i && (write_addr_i == raddr[p])) begin
          rdata[p] = write_data_i;
        end else begin
          rdata[p] = rd_entry[p][DATA_W-1:0];
`ifdef RF_PARITY_EN
          perr[p]  = ^rd_entry[p];
`endif
        end
      end
    end
  end

  assign read_data1_o = rdata[0];
  assign read_data2_o = rdata[1];
  assign ready_o      = ready_q;
`ifdef RF_PARITY_EN
  assign parity_err_o = perr;
`endif

endmodule
